// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC controller: register map, ID word,
// FSM states, frame field widths and the round-robin channel picker.
package dac_pkg;

    localparam logic [3:0] REG_VALUE    = 4'h1;
    localparam logic [3:0] REG_CONTROL  = 4'h2;
    localparam logic [3:0] REG_LDAC_NOW = 4'h3;
    localparam logic [3:0] REG_ID       = 4'h9;
    localparam logic [3:0] REG_BUSY     = 4'hA;
    localparam logic [3:0] REG_PENDING  = 4'hB;

    localparam logic [15:0] DAC_ID = 16'h0DAC;

    localparam int FRAME_W = 16;
    localparam int CH_W    = 3;
    localparam int VALUE_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_LDAC
    } state_t;

    // First set bit of pend at or after ptr, wrapping modulo n.
    function automatic logic [CH_W-1:0] rr_pick(input logic [7:0] pend,
                                                input logic [CH_W-1:0] ptr,
                                                input int n);
        int idx;
        rr_pick = ptr;
        for (int i = n - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx -= n;
            if (pend[idx]) rr_pick = CH_W'(idx);
        end
    endfunction

endpackage

// File: rtl/dac_shifter.sv
// Serialises one 16-bit frame: divides clk into dac_sclk, presents each bit
// before the falling edge and shifts on the rising edge.
import dac_pkg::*;

module dac_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] word,
    output logic               done,
    output logic               sclk,
    output logic               din,
    output logic               frame_active
);

    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [7:0]         div_q, div_d;
    logic [3:0]         bit_q, bit_d;
    logic               sclk_q, sclk_d;
    logic               active_q, active_d;
    logic               tick;

    assign tick = active_q && (div_q == 8'(CLK_DIV - 1));

    always_comb begin
        shift_d  = shift_q;
        div_d    = div_q;
        bit_d    = bit_q;
        sclk_d   = sclk_q;
        active_d = active_q;
        done     = 1'b0;
        if (start && !active_q) begin
            shift_d  = word;
            active_d = 1'b1;
            div_d    = '0;
            bit_d    = '0;
            sclk_d   = 1'b1;
        end else if (active_q) begin
            if (tick) begin
                div_d = '0;
                if (sclk_q) begin
                    sclk_d = 1'b0;
                end else begin
                    // After 16 shifts the register is all zeros, so din idles low.
                    sclk_d  = 1'b1;
                    shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == 4'd15) begin
                        active_d = 1'b0;
                        done     = 1'b1;
                    end
                end
            end else begin
                div_d = div_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q  <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            sclk_q   <= 1'b1;
            active_q <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            sclk_q   <= sclk_d;
            active_q <= active_d;
        end
    end

    assign sclk         = sclk_q;
    assign din          = shift_q[FRAME_W-1];
    assign frame_active = active_q;

endmodule

// File: rtl/dac_control.sv
// Bus-mapped 8-channel serial DAC controller: shadow registers, round-robin
// frame arbitration, inter-frame gap and LDAC pulse generation.
import dac_pkg::*;

module dac_control #(
    parameter int NUM_CHANNELS = 8,
    parameter int CLK_DIV      = 4,
    parameter int CS_GAP       = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [31:0] data_in,
    input  logic        enable,
    input  logic        re,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        dac_sclk,
    output logic        dac_sync_n,
    output logic        dac_din,
    output logic        dac_ldac_n
);

    state_t                  state_q, state_d;
    logic [VALUE_W-1:0]      shadow_q [NUM_CHANNELS];
    logic [VALUE_W-1:0]      shadow_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] pending_q, pending_d;
    logic [CH_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             data_out_q, data_out_d;
    logic                    auto_ldac_q, auto_ldac_d;
    logic                    ldac_req_q, ldac_req_d;
    logic                    sync_n_q, sync_n_d;
    logic                    ldac_n_q, ldac_n_d;

    logic               ch_ok, busy, shift_start, shift_done, shift_active;
    logic [CH_W-1:0]    bus_ch, sel;
    logic [3:0]         bus_reg;
    logic [FRAME_W-1:0] frame_word;
    logic               unused_bits;

    assign bus_ch      = addr[8 +: CH_W];
    assign bus_reg     = addr[3:0];
    assign ch_ok       = enable && (int'(addr[15:8]) < NUM_CHANNELS);
    assign busy        = (state_q != ST_IDLE) || (pending_q != '0);
    assign sel         = rr_pick(8'(pending_q), rr_ptr_q, NUM_CHANNELS);
    assign frame_word  = {1'b0, sel, shadow_q[sel]};
    assign unused_bits = ^{addr[7:4], data_in[31:VALUE_W]};

    dac_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
        .clk          (clk),
        .reset        (reset),
        .start        (shift_start),
        .word         (frame_word),
        .done         (shift_done),
        .sclk         (dac_sclk),
        .din          (dac_din),
        .frame_active (shift_active)
    );

    always_comb begin
        state_d     = state_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        auto_ldac_d = auto_ldac_q;
        ldac_req_d  = ldac_req_q;
        sync_n_d    = sync_n_q;
        ldac_n_d    = ldac_n_q;
        data_out_d  = '0;
        shift_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pending_q != '0 && !shift_active) begin
                    shift_start    = 1'b1;
                    pending_d[sel] = 1'b0;
                    rr_ptr_d       = (sel == CH_W'(NUM_CHANNELS - 1)) ? '0 : sel + 1'b1;
                    sync_n_d       = 1'b0;
                    state_d        = ST_SHIFT;
                end else if (ldac_req_q) begin
                    ldac_req_d = 1'b0;
                    ldac_n_d   = 1'b0;
                    cnt_d      = '0;
                    state_d    = ST_LDAC;
                end
            end
            ST_SHIFT: begin
                if (shift_done) begin
                    sync_n_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_GAP;
                end
            end
            ST_GAP: begin
                if (cnt_q == 16'(CS_GAP - 1)) begin
                    if ((auto_ldac_q && pending_q == '0) || ldac_req_q) begin
                        ldac_req_d = 1'b0;
                        ldac_n_d   = 1'b0;
                        cnt_d      = '0;
                        state_d    = ST_LDAC;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_LDAC: begin
                if (cnt_q == 16'(2 * CLK_DIV - 1)) begin
                    ldac_n_d = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Bus writes come last so they win over the arbiter and LDAC clears.
        if (ch_ok && wr) begin
            case (bus_reg)
                REG_VALUE: begin
                    shadow_d[bus_ch]  = data_in[VALUE_W-1:0];
                    pending_d[bus_ch] = 1'b1;
                end
                REG_CONTROL:  auto_ldac_d = data_in[0];
                REG_LDAC_NOW: ldac_req_d  = 1'b1;
                default: ;
            endcase
        end

        if (ch_ok && re) begin
            case (bus_reg)
                REG_VALUE:   data_out_d = {4'h0, shadow_q[bus_ch]};
                REG_CONTROL: data_out_d = {15'h0, auto_ldac_q};
                REG_ID:      data_out_d = DAC_ID;
                REG_BUSY:    data_out_d = {15'h0, busy};
                REG_PENDING: data_out_d = {8'h0, 8'(pending_q)};
                default:     data_out_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NUM_CHANNELS; i++) shadow_q[i] <= '0;
            pending_q   <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            auto_ldac_q <= 1'b1;
            ldac_req_q  <= 1'b0;
            sync_n_q    <= 1'b1;
            ldac_n_q    <= 1'b1;
            data_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            auto_ldac_q <= auto_ldac_d;
            ldac_req_q  <= ldac_req_d;
            sync_n_q    <= sync_n_d;
            ldac_n_q    <= ldac_n_d;
            data_out_q  <= data_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign dac_sync_n = sync_n_q;
    assign dac_ldac_n = ldac_n_q;

endmodule

// File: tb/tb_dac_control.sv
// Randomised bench for dac_control: a pin monitor decodes frames and LDAC
// pulses, compared against a round-robin model of expected pin activity.
module tb_dac_control;

    localparam int NCH  = 8;
    localparam int CDIV = 2;
    localparam int GAP  = 2;

    localparam logic [3:0] R_VALUE = 4'h1, R_CONTROL = 4'h2, R_LDAC = 4'h3;
    localparam logic [3:0] R_ID = 4'h9, R_BUSY = 4'hA, R_PEND = 4'hB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] addr = '0;
    logic [31:0] data_in = '0;
    logic        enable = 1'b0, re = 1'b0, wr = 1'b0;
    logic [15:0] data_out;
    logic        dac_sclk, dac_sync_n, dac_din, dac_ldac_n;

    dac_control #(.NUM_CHANNELS(NCH), .CLK_DIV(CDIV), .CS_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .addr(addr), .data_in(data_in),
        .enable(enable), .re(re), .wr(wr), .data_out(data_out),
        .dac_sclk(dac_sclk), .dac_sync_n(dac_sync_n), .dac_din(dac_din),
        .dac_ldac_n(dac_ldac_n)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // Observed pin events: frames as 0x1_wwww, LDAC pulses as 0x2_llll.
    int ev_q[$];
    int len_q[$];
    int partial = 0, last_gap = -1, bits_seen = 0;

    // Reference model state.
    int          exp_q[$];
    int          m_rr = 0;
    logic [11:0] m_shadow [NCH];
    int          b_ch [4];
    int          b_n = 0;

    initial begin
        logic        prev_sclk = 1'b1, prev_sync = 1'b1, prev_ldac = 1'b1;
        logic [15:0] shreg = '0;
        int          sync_len = 0, ldac_len = 0, hi_cnt = 0;
        forever begin
            @(negedge clk);
            if (!dac_sync_n) begin
                sync_len++;
                if (prev_sclk && !dac_sclk) begin
                    shreg = {shreg[14:0], dac_din};
                    bits_seen++;
                end
            end
            if (dac_sync_n && !prev_sync) begin
                if (bits_seen == 16) begin
                    ev_q.push_back(32'h10000 | int'(shreg));
                    len_q.push_back(sync_len);
                end else begin
                    partial++;
                end
                bits_seen = 0;
                sync_len  = 0;
            end
            if (!dac_ldac_n) ldac_len++;
            if (prev_ldac && !dac_ldac_n) last_gap = hi_cnt;
            if (dac_ldac_n && !prev_ldac) begin
                ev_q.push_back(32'h20000 | ldac_len);
                len_q.push_back(ldac_len);
                ldac_len = 0;
            end
            if (dac_sync_n) hi_cnt++;
            else hi_cnt = 0;
            prev_sclk = dac_sclk;
            prev_sync = dac_sync_n;
            prev_ldac = dac_ldac_n;
        end
    end

    function automatic logic [15:0] a_of(input int ch, input logic [3:0] r);
        return {8'(ch), 4'h0, r};
    endfunction

    function automatic void m_frame(input int ch);
        exp_q.push_back(32'h10000 | (ch << 12) | int'(m_shadow[ch]));
        m_rr = (ch + 1) % NCH;
    endfunction

    function automatic void m_ldac();
        exp_q.push_back(32'h20000 | (2 * CDIV));
    endfunction

    // A burst written while idle: the first write is sent at once, the rest
    // are drained round-robin from the channel after the one just sent.
    function automatic void m_burst(input logic auto_l);
        bit pend [NCH];
        bit any;
        int pick;
        for (int i = 0; i < NCH; i++) pend[i] = 1'b0;
        m_frame(b_ch[0]);
        for (int k = 1; k < b_n; k++) pend[b_ch[k]] = 1'b1;
        do begin
            any = 1'b0;
            pick = 0;
            for (int off = NCH - 1; off >= 0; off--)
                if (pend[(m_rr + off) % NCH]) begin
                    any = 1'b1;
                    pick = (m_rr + off) % NCH;
                end
            if (any) begin
                pend[pick] = 1'b0;
                m_frame(pick);
            end
        end while (any);
        if (auto_l) m_ldac();
    endfunction

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        $display("write addr=%04h data=%08h", a, d);
        addr = a; data_in = d; enable = 1'b1; wr = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] q);
        addr = a; enable = 1'b1; re = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0; re = 1'b0;
        q = data_out;
    endtask

    task automatic wait_idle(input string tag);
        logic [15:0] b;
        int zeros = 0, n = 0;
        repeat (4) @(posedge clk);
        #1;
        while (zeros < 3 && n < 3000) begin
            bus_read(a_of(0, R_BUSY), b);
            zeros = (b == 16'h0) ? zeros + 1 : 0;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (zeros < 3) begin
            bad++;
            $display("FAIL %s_idle_timeout busy=%0h required=0", tag, b);
        end
    endtask

    task automatic test_reset();
        logic [15:0] q;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        total++;
        if ({dac_sclk, dac_sync_n, dac_ldac_n, dac_din, data_out} !== {4'b1110, 16'h0}) begin
            bad++;
            $display("FAIL reset_pins got=%b%b%b%b/%h required=1110/0000",
                     dac_sclk, dac_sync_n, dac_ldac_n, dac_din, data_out);
        end
        bus_read(a_of(0, R_ID), q);
        total++;
        if (q !== 16'h0DAC) begin bad++; $display("FAIL id got=%h required=0dac", q); end
        @(posedge clk); #1;
        total++;
        if (data_out !== 16'h0) begin bad++; $display("FAIL idle_data_out got=%h required=0", data_out); end
        bus_read(a_of(0, R_BUSY), q);
        total++;
        if (q !== 16'h0) begin bad++; $display("FAIL busy_reset got=%h required=0", q); end
        bus_read(a_of(0, R_CONTROL), q);
        total++;
        if (q !== 16'h1) begin bad++; $display("FAIL control_reset got=%h required=1", q); end
        bus_read(a_of(9, R_ID), q);
        total++;
        if (q !== 16'h0) begin bad++; $display("FAIL bad_channel_read got=%h required=0", q); end
        bus_write(a_of(8, R_VALUE), 32'h123);
        bus_read(a_of(0, R_PEND), q);
        total++;
        if (q !== 16'h0) begin bad++; $display("FAIL bad_channel_write pending=%h required=0", q); end
        for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
        m_rr = 0;
    endtask

    task automatic test_single();
        ev_q.delete(); len_q.delete(); exp_q.delete();
        m_shadow[3] = 12'hABC;
        b_ch[0] = 3; b_n = 1;
        m_burst(1'b1);
        bus_write(a_of(3, R_VALUE), 32'hABC);
        wait_idle("single");
        total++;
        if (ev_q.size() !== exp_q.size()) begin bad++; $display("FAIL single_count got=%0d required=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin bad++; $display("FAIL single_ev%0d got=%h required=%h", i, ev_q[i], exp_q[i]); end
            if (ev_q[i] >= 32'h20000) continue;
            total++;
            if (len_q[i] !== 32 * CDIV) begin bad++; $display("FAIL single_sync_len got=%0d required=%0d", len_q[i], 32 * CDIV); end
        end
        total++;
        if (last_gap !== GAP) begin bad++; $display("FAIL single_gap got=%0d required=%0d", last_gap, GAP); end
    endtask

    task automatic test_back_to_back();
        ev_q.delete(); len_q.delete(); exp_q.delete();
        b_ch[0] = 5; b_ch[1] = 1; b_ch[2] = 6; b_n = 3;
        m_shadow[5] = 12'h111; m_shadow[1] = 12'h222; m_shadow[6] = 12'h333;
        m_burst(1'b1);
        bus_write(a_of(5, R_VALUE), 32'h111);
        bus_write(a_of(1, R_VALUE), 32'h222);
        bus_write(a_of(6, R_VALUE), 32'h333);
        wait_idle("b2b");
        total++;
        if (ev_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d required=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b_ev%0d got=%h required=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_no_auto();
        logic [15:0] q;
        ev_q.delete(); len_q.delete(); exp_q.delete();
        bus_write(a_of(0, R_CONTROL), 32'h0);
        bus_read(a_of(0, R_CONTROL), q);
        total++;
        if (q !== 16'h0) begin bad++; $display("FAIL control_rd got=%h required=0", q); end
        m_shadow[0] = 12'h7FF;
        b_ch[0] = 0; b_n = 1;
        m_burst(1'b0);
        bus_write(a_of(0, R_VALUE), 32'h7FF);
        wait_idle("noauto");
        m_ldac();
        bus_write(a_of(0, R_LDAC), 32'h1);
        wait_idle("ldacnow");
        // Second request lands while the first pulse is in progress.
        m_ldac(); m_ldac();
        bus_write(a_of(0, R_LDAC), 32'h1);
        @(posedge clk); #1;
        bus_write(a_of(0, R_LDAC), 32'h1);
        wait_idle("ldac_twice");
        total++;
        if (ev_q.size() !== exp_q.size()) begin bad++; $display("FAIL noauto_count got=%0d required=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin bad++; $display("FAIL noauto_ev%0d got=%h required=%h", i, ev_q[i], exp_q[i]); end
        end
        bus_write(a_of(0, R_CONTROL), 32'h1);
    endtask

    task automatic test_rewrite();
        logic [15:0] q;
        ev_q.delete(); len_q.delete(); exp_q.delete();
        m_shadow[2] = 12'h0F0;
        m_frame(2);
        m_shadow[2] = 12'h555;
        m_frame(2);
        m_ldac();
        bus_write(a_of(2, R_VALUE), 32'h0F0);
        repeat (20) @(posedge clk);
        #1;
        bus_write(a_of(2, R_VALUE), 32'h555);
        bus_read(a_of(0, R_PEND), q);
        total++;
        if (q !== 16'h0004) begin bad++; $display("FAIL rewrite_pending got=%h required=0004", q); end
        bus_read(a_of(2, R_VALUE), q);
        total++;
        if (q !== 16'h0555) begin bad++; $display("FAIL rewrite_value got=%h required=0555", q); end
        wait_idle("rewrite");
        total++;
        if (ev_q.size() !== exp_q.size()) begin bad++; $display("FAIL rewrite_count got=%0d required=%0d", ev_q.size(), exp_q.size()); end
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (ev_q[i] !== exp_q[i]) begin bad++; $display("FAIL rewrite_ev%0d got=%h required=%h", i, ev_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] q;
        int n = 0;
        ev_q.delete(); len_q.delete(); partial = 0;
        bus_write(a_of(4, R_VALUE), 32'h9A5);
        bus_write(a_of(6, R_VALUE), 32'h123);
        while (bits_seen < 7 && n < 500) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bits_seen < 7) begin bad++; $display("FAIL midreset_timeout bits=%0d required=7", bits_seen); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({dac_sync_n, dac_sclk} !== 2'b11) begin
            bad++;
            $display("FAIL midreset_pins sync_n,sclk=%b%b required=11", dac_sync_n, dac_sclk);
        end
        @(posedge clk); #1;
        bus_read(a_of(0, R_PEND), q);
        total++;
        if (q !== 16'h0) begin bad++; $display("FAIL midreset_pending got=%h required=0", q); end
        bus_read(a_of(4, R_VALUE), q);
        total++;
        if (q !== 16'h0) begin bad++; $display("FAIL midreset_shadow got=%h required=0", q); end
        repeat (200) @(posedge clk);
        #1;
        total++;
        if (ev_q.size() !== 0 || partial !== 1) begin
            bad++;
            $display("FAIL midreset_frames got=%0d/%0d required=0/1", ev_q.size(), partial);
        end
        for (int i = 0; i < NCH; i++) m_shadow[i] = '0;
        m_rr = 0;
    endtask

    task automatic test_random();
        int perm [NCH];
        int j, t;
        logic [11:0] v;
        for (int it = 0; it < 6; it++) begin
            ev_q.delete(); len_q.delete(); exp_q.delete();
            for (int i = 0; i < NCH; i++) perm[i] = i;
            for (int i = NCH - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            b_n = $urandom_range(4, 1);
            for (int k = 0; k < b_n; k++) b_ch[k] = perm[k];
            for (int k = 0; k < b_n; k++) begin
                v = 12'($urandom);
                m_shadow[b_ch[k]] = v;
            end
            m_burst(1'b1);
            for (int k = 0; k < b_n; k++)
                bus_write(a_of(b_ch[k], R_VALUE), {20'($urandom), m_shadow[b_ch[k]]});
            wait_idle("random");
            total++;
            if (ev_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd%0d_count got=%0d required=%0d", it, ev_q.size(), exp_q.size()); end
            for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
                total++;
                if (ev_q[i] !== exp_q[i]) begin bad++; $display("FAIL rnd%0d_ev%0d got=%h required=%h", it, i, ev_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_no_auto();
        test_rewrite();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
